// File: rtl/comfort_ctrl_if.sv
// Signal bundle between the DHT11 reader side and the comfort controller:
// sensor reading and setpoint in, actuator and status outputs back.
interface comfort_ctrl_if;
    logic       done_i;
    logic [7:0] temp_i;
    logic [7:0] hum_i;
    logic [7:0] setpoint_i;
    logic       heat_o;
    logic       fan_pwm_o;
    logic [7:0] fan_duty_o;
    logic [1:0] mode_o;
    logic [7:0] temp_avg_o;
    logic [7:0] hum_avg_o;
    logic       avg_valid_o;
    logic       alarm_o;
    logic       stale_o;

    modport master (
        output done_i, temp_i, hum_i, setpoint_i,
        input  heat_o, fan_pwm_o, fan_duty_o, mode_o, temp_avg_o, hum_avg_o,
               avg_valid_o, alarm_o, stale_o
    );

    modport slave (
        input  done_i, temp_i, hum_i, setpoint_i,
        output heat_o, fan_pwm_o, fan_duty_o, mode_o, temp_avg_o, hum_avg_o,
               avg_valid_o, alarm_o, stale_o
    );
endinterface

// File: rtl/comfort_ctrl.sv
// Comfort controller: 4-sample moving average of temperature/humidity, hysteresis
// heater/fan state machine, PWM fan drive, alarm and stale-sensor watchdog.
module comfort_ctrl #(
    parameter int CLK_HZ       = 16000000,
    parameter int HYST         = 1,
    parameter int GAIN         = 32,
    parameter int T_MIN        = 18,
    parameter int T_MAX        = 30,
    parameter int HUM_MAX      = 70,
    parameter int HUM_DUTY     = 64,
    parameter int FAULT_DUTY   = 128,
    parameter int PWM_DIV      = 64,
    parameter int STALE_CYCLES = 3 * CLK_HZ
) (
    input  logic          clk_i,
    input  logic          rst_i,
    comfort_ctrl_if.slave bus
);
    localparam int WIN  = 4;
    localparam int WD_W = $clog2(STALE_CYCLES + 1);
    localparam int PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [WD_W-1:0] STALE_VAL   = WD_W'(STALE_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PWM_DIV - 1);
    localparam logic [9:0]      HYST10      = 10'(HYST);
    localparam logic [9:0]      GAIN10      = 10'(GAIN);
    localparam logic [9:0]      T_MIN10     = 10'(T_MIN);
    localparam logic [9:0]      T_MAX10     = 10'(T_MAX);
    localparam logic [9:0]      HUM_MAX10   = 10'(HUM_MAX);
    localparam logic [7:0]      HUM_DUTY8   = 8'(HUM_DUTY);
    localparam logic [7:0]      FAULT_DUTY8 = 8'(FAULT_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAT  = 2'd1,
        ST_COOL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    logic done_q_reg;
    logic accept;
    logic acc_q_reg;
    logic upd_reg;

    logic [7:0] temp_win_reg  [WIN];
    logic [7:0] hum_win_reg   [WIN];
    logic [7:0] temp_win_next [WIN];
    logic [7:0] hum_win_next  [WIN];
    logic       win_loaded_reg;
    logic [9:0] temp_sum;
    logic [9:0] hum_sum;
    logic [7:0] temp_avg_reg;
    logic [7:0] hum_avg_reg;
    logic       avg_valid_reg;

    logic [WD_W-1:0] wd_cnt_reg;
    logic            stale_reg;
    logic            stale_next;

    state_t     state_reg, state_next;
    logic       heat_reg, heat_next;
    logic [7:0] duty_reg, duty_next;
    logic       alarm_reg, alarm_next;
    logic [9:0] t_avg10, h_avg10, sp10, diff10;
    logic [19:0] cool_prod;
    logic [7:0] cool_duty;

    logic [PS_W-1:0] presc_reg;
    logic [7:0]      pwm_cnt_reg;
    logic [7:0]      active_duty_reg;
    logic            pwm_step;

    // Rising edge of done_i only; a held level produces a single sample.
    assign accept = bus.done_i & ~done_q_reg;

    // Entry 0 takes the new reading; later entries shift, or all preload on the first sample.
    genvar gi;
    generate
        for (gi = 0; gi < WIN; gi++) begin : g_win
            if (gi == 0) begin : g_head
                assign temp_win_next[gi] = bus.temp_i;
                assign hum_win_next[gi]  = bus.hum_i;
            end else begin : g_tail
                assign temp_win_next[gi] = win_loaded_reg ? temp_win_reg[gi-1] : bus.temp_i;
                assign hum_win_next[gi]  = win_loaded_reg ? hum_win_reg[gi-1]  : bus.hum_i;
            end
        end
    endgenerate

    always_comb begin
        temp_sum = '0;
        hum_sum  = '0;
        for (int i = 0; i < WIN; i++) begin
            temp_sum = temp_sum + {2'b00, temp_win_reg[i]};
            hum_sum  = hum_sum  + {2'b00, hum_win_reg[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q_reg     <= 1'b0;
            acc_q_reg      <= 1'b0;
            upd_reg        <= 1'b0;
            win_loaded_reg <= 1'b0;
            temp_avg_reg   <= '0;
            hum_avg_reg    <= '0;
            avg_valid_reg  <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                temp_win_reg[i] <= '0;
                hum_win_reg[i]  <= '0;
            end
        end else begin
            done_q_reg    <= bus.done_i;
            acc_q_reg     <= accept;
            upd_reg       <= acc_q_reg;
            temp_avg_reg  <= temp_sum[9:2];
            hum_avg_reg   <= hum_sum[9:2];
            avg_valid_reg <= win_loaded_reg;
            if (accept) begin
                temp_win_reg   <= temp_win_next;
                hum_win_reg    <= hum_win_next;
                win_loaded_reg <= 1'b1;
            end
        end
    end

    // A sample landing in the threshold cycle clears the count before the fault is raised.
    assign stale_next = (wd_cnt_reg == STALE_VAL) && !accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_reg <= '0;
            stale_reg  <= 1'b0;
        end else begin
            stale_reg <= stale_next;
            if (accept)
                wd_cnt_reg <= '0;
            else if (wd_cnt_reg != STALE_VAL)
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
    end

    assign t_avg10   = {2'b00, temp_avg_reg};
    assign h_avg10   = {2'b00, hum_avg_reg};
    assign sp10      = {2'b00, bus.setpoint_i};
    assign diff10    = t_avg10 - sp10;
    assign cool_prod = {10'd0, diff10} * {10'd0, GAIN10};
    assign cool_duty = (cool_prod > 20'd255) ? 8'hFF : cool_prod[7:0];

    always_comb begin
        state_next = state_reg;
        heat_next  = heat_reg;
        duty_next  = duty_reg;
        alarm_next = alarm_reg;
        if (stale_next) begin
            state_next = ST_FAULT;
            heat_next  = 1'b0;
            duty_next  = FAULT_DUTY8;
        end else if (upd_reg) begin
            // FAULT leaves through the IDLE rules using the fresh average.
            case (state_reg)
                ST_HEAT: state_next = (t_avg10 >= sp10) ? ST_IDLE : ST_HEAT;
                ST_COOL: state_next = (t_avg10 <= sp10) ? ST_IDLE : ST_COOL;
                default: begin
                    if (t_avg10 + HYST10 < sp10)
                        state_next = ST_HEAT;
                    else if (t_avg10 > sp10 + HYST10)
                        state_next = ST_COOL;
                    else
                        state_next = ST_IDLE;
                end
            endcase
            alarm_next = (t_avg10 < T_MIN10) || (t_avg10 > T_MAX10);
            case (state_next)
                ST_HEAT: begin
                    heat_next = 1'b1;
                    duty_next = 8'd0;
                end
                ST_COOL: begin
                    heat_next = 1'b0;
                    duty_next = cool_duty;
                end
                default: begin
                    heat_next = 1'b0;
                    duty_next = (h_avg10 > HUM_MAX10) ? HUM_DUTY8 : 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            heat_reg  <= 1'b0;
            duty_reg  <= '0;
            alarm_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            heat_reg  <= heat_next;
            duty_reg  <= duty_next;
            alarm_reg <= alarm_next;
        end
    end

    // New duty only takes effect at a period boundary so no PWM period is truncated.
    assign pwm_step = (presc_reg == PS_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_reg       <= '0;
            pwm_cnt_reg     <= '0;
            active_duty_reg <= '0;
        end else begin
            presc_reg <= pwm_step ? '0 : presc_reg + PS_W'(1);
            if (pwm_step) begin
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
                if (pwm_cnt_reg == 8'hFF)
                    active_duty_reg <= duty_reg;
            end
        end
    end

    assign bus.heat_o      = heat_reg;
    assign bus.fan_pwm_o   = (pwm_cnt_reg < active_duty_reg);
    assign bus.fan_duty_o  = duty_reg;
    assign bus.mode_o      = state_reg;
    assign bus.temp_avg_o  = temp_avg_reg;
    assign bus.hum_avg_o   = hum_avg_reg;
    assign bus.avg_valid_o = avg_valid_reg;
    assign bus.alarm_o     = alarm_reg;
    assign bus.stale_o     = stale_reg;
endmodule
